// File: rtl/kbd_ascii_fifo.sv
// kbd_ascii_fifo: PS/2 set-2 scan bytes -> ASCII, buffered in a first-word-fall-through FIFO.
// Build option KBD_CAPSLOCK_EN adds a caps-lock toggle on scan code 0x58.
module kbd_ascii_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [7:0]    kb_byte,
  input  logic          kb_valid,
  output logic          kb_clr,
  input  logic          rd_en,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          shift_o,
  output logic [1:0]    state_o
);
  // Handshake: kb_valid is a sticky flag; a byte is taken when kb_valid=1 and
  // kb_clr=0, kb_clr pulses for exactly the following cycle, and kb_valid is
  // ignored during that pulse. rd_en pops one char per high cycle when not empty.
  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t          state_q, state_d;
  logic            kb_clr_q, byte_vld_q;
  logic [7:0]      byte_q;
  logic            lshift_q, lshift_d, rshift_q, rshift_d;
  logic            caps_w;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem [DEPTH];

  logic            accept, push_req, wr_en, rd_do, is_let, up_sym, up_let;
  logic [7:0]      lo, hi, key_ch, push_ch;

`ifdef KBD_CAPSLOCK_EN
  logic caps_q, caps_d;
  assign caps_w = caps_q;
`else
  assign caps_w = 1'b0;
`endif

  assign accept  = kb_valid & ~kb_clr_q;
  assign up_sym  = lshift_q | rshift_q;
  assign up_let  = up_sym ^ caps_w;

  // lo = unshifted glyph (0 = unmapped key); hi = shifted glyph for non-letters
  always_comb begin
    lo = 8'h00;
    hi = 8'h00;
    case (byte_q)
      8'h1C: lo = "a";  8'h32: lo = "b";  8'h21: lo = "c";  8'h23: lo = "d";
      8'h24: lo = "e";  8'h2B: lo = "f";  8'h34: lo = "g";  8'h33: lo = "h";
      8'h43: lo = "i";  8'h3B: lo = "j";  8'h42: lo = "k";  8'h4B: lo = "l";
      8'h3A: lo = "m";  8'h31: lo = "n";  8'h44: lo = "o";  8'h4D: lo = "p";
      8'h15: lo = "q";  8'h2D: lo = "r";  8'h1B: lo = "s";  8'h2C: lo = "t";
      8'h3C: lo = "u";  8'h2A: lo = "v";  8'h1D: lo = "w";  8'h22: lo = "x";
      8'h35: lo = "y";  8'h1A: lo = "z";
      8'h45: {lo, hi} = {"0", ")"};  8'h16: {lo, hi} = {"1", "!"};
      8'h1E: {lo, hi} = {"2", "@"};  8'h26: {lo, hi} = {"3", "#"};
      8'h25: {lo, hi} = {"4", "$"};  8'h2E: {lo, hi} = {"5", "%"};
      8'h36: {lo, hi} = {"6", "^"};  8'h3D: {lo, hi} = {"7", "&"};
      8'h3E: {lo, hi} = {"8", "*"};  8'h46: {lo, hi} = {"9", "("};
      8'h4E: {lo, hi} = {"-", "_"};  8'h55: {lo, hi} = {"=", "+"};
      8'h54: {lo, hi} = {"[", "{"};  8'h5B: {lo, hi} = {"]", "}"};
      8'h4C: {lo, hi} = {";", ":"};  8'h52: {lo, hi} = {"'", "\""};
      8'h41: {lo, hi} = {",", "<"};  8'h49: {lo, hi} = {".", ">"};
      8'h4A: {lo, hi} = {"/", "?"};  8'h0E: {lo, hi} = {8'h60, "~"};
      8'h5D: {lo, hi} = {"\\", "|"};
      8'h29: {lo, hi} = {8'h20, 8'h20};  8'h5A: {lo, hi} = {8'h0D, 8'h0D};
      8'h66: {lo, hi} = {8'h08, 8'h08};  8'h76: {lo, hi} = {8'h1B, 8'h1B};
      8'h0D: {lo, hi} = {8'h09, 8'h09};
      default: begin
        lo = 8'h00;
        hi = 8'h00;
      end
    endcase
    is_let = (lo >= "a") && (lo <= "z");
    key_ch = is_let ? (up_let ? (lo - 8'h20) : lo) : (up_sym ? hi : lo);
  end

  always_comb begin
    state_d  = state_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
`ifdef KBD_CAPSLOCK_EN
    caps_d   = caps_q;
`endif
    push_req = 1'b0;
    push_ch  = key_ch;
    if (byte_vld_q) begin
      case (state_q)
        S_IDLE: begin
          if (byte_q == 8'hE0)      state_d = S_EXT;
          else if (byte_q == 8'hF0) state_d = S_BRK;
          else begin
            if (byte_q == 8'h12) lshift_d = 1'b1;
            if (byte_q == 8'h59) rshift_d = 1'b1;
`ifdef KBD_CAPSLOCK_EN
            if (byte_q == 8'h58) caps_d = ~caps_q;
`endif
            push_req = (lo != 8'h00);
          end
        end
        S_EXT: begin
          if (byte_q == 8'hF0)      state_d = S_EXT_BRK;
          else if (byte_q != 8'hE0) begin
            state_d  = S_IDLE;
            push_req = (byte_q == 8'h5A);
            push_ch  = 8'h0D;
          end
        end
        S_BRK: begin
          if (byte_q == 8'h12) lshift_d = 1'b0;
          if (byte_q == 8'h59) rshift_d = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A write into a full FIFO still lands when a pop happens in the same cycle
  always_comb begin
    wr_en    = push_req & (~full | rd_en);
    rd_do    = rd_en & ~empty;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_do ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_do);
    if (push_req & full & ~rd_en) ovf_d = 1'b1;
    else if (ovf_clr)             ovf_d = 1'b0;
    else                          ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      kb_clr_q   <= 1'b0;
      byte_vld_q <= 1'b0;
      byte_q     <= 8'h00;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
`ifdef KBD_CAPSLOCK_EN
      caps_q     <= 1'b0;
`endif
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      kb_clr_q   <= accept;
      byte_vld_q <= accept;
      if (accept) byte_q <= kb_byte;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
`ifdef KBD_CAPSLOCK_EN
      caps_q     <= caps_d;
`endif
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= push_ch;
  end

  assign kb_clr   = kb_clr_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign dout     = empty ? 8'h00 : mem[rd_ptr_q];
  assign overflow = ovf_q;
  assign shift_o  = up_sym ^ caps_w;
  assign state_o  = state_q;
endmodule
